// File: rtl/rgb2grey_pkg.sv
// Shared types and luma coefficients for the rgb2grey arbiter slice.
// Y = (77R + 150G + 29B) >> 8, taken from a 16-bit sum.
package rgb2grey_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic [23:0] rgb888_t;

    localparam logic [15:0] Y_COEF_R = 16'd77;
    localparam logic [15:0] Y_COEF_G = 16'd150;
    localparam logic [15:0] Y_COEF_B = 16'd29;

    // The coefficients sum to 256, so the worst case (65280) still fits in 16 bits.
    function automatic logic [7:0] luma(input rgb888_t pix);
        logic [15:0] sum;
        sum = Y_COEF_R * {8'd0, pix[23:16]}
            + Y_COEF_G * {8'd0, pix[15:8]}
            + Y_COEF_B * {8'd0, pix[7:0]};
        return sum[15:8];
    endfunction

endpackage

// File: rtl/rgb2grey_arb_if.sv
// Request/beat bundle from the N_CH requesters plus the tagged grey output stream.
interface rgb2grey_arb_if #(parameter int N_CH = 4);
    import rgb2grey_pkg::*;

    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    valid;
    logic [N_CH-1:0]    last;
    logic [N_CH*24-1:0] data;
    logic [N_CH-1:0]    ready;
    logic [N_CH-1:0]    grant;

    logic               y_valid;
    rgb888_t            y_data;
    logic [ID_W-1:0]    y_id;
    logic               y_last;

    modport master (
        output req, valid, last, data,
        input  ready, grant, y_valid, y_data, y_id, y_last
    );

    modport slave (
        input  req, valid, last, data,
        output ready, grant, y_valid, y_data, y_id, y_last
    );
endinterface

// File: rtl/rgb2grey.sv
// RGB888 to grey converter; init_i starts a conversion, done_o marks the {Y,Y,Y} result.
module rgb2grey
    import rgb2grey_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  logic    init_i,
    input  rgb888_t data_i,
    output logic    done_o,
    output rgb888_t data_o
);
    logic [7:0] y_comb;

    assign y_comb = luma(data_i);

    generate
        if (OUT_REG) begin : g_reg
            logic    done_reg;
            rgb888_t data_reg;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    done_reg <= 1'b0;
                    data_reg <= '0;
                end else begin
                    done_reg <= init_i;
                    if (init_i) begin
                        data_reg <= {3{y_comb}};
                    end
                end
            end

            assign done_o = done_reg;
            assign data_o = data_reg;
        end else begin : g_comb
            assign done_o = init_i;
            assign data_o = {3{y_comb}};
        end
    endgenerate
endmodule

// File: rtl/rgb2grey_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_CH.
module rgb2grey_rr_pick #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [N_CH-1:0] onehot,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    logic [2*N_CH-2:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [ID_W-1:0]   off;
    logic [ID_W:0]     sum;

    // Doubling the vector lets a plain slice stand in for a rotate by ptr.
    assign req_dbl = {req[N_CH-2:0], req};

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_rot
            logic [ID_W:0] pos;
            assign pos         = {1'b0, ptr} + (ID_W+1)'(gi);
            assign req_rot[gi] = req_dbl[pos];
        end
    endgenerate

    always_comb begin
        off    = '0;
        onehot = '0;
        any    = |req;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(N_CH)) begin
            sum = sum - (ID_W+1)'(N_CH);
        end
        idx = sum[ID_W-1:0];
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/rgb2grey_arb.sv
// Burst-level round-robin arbiter sharing one rgb2grey converter among N_CH requesters;
// grey results come back tagged with the owning channel id.
module rgb2grey_arb
    import rgb2grey_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int MAX_BURST = 256
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    rgb2grey_arb_if.slave bus
);
    localparam int ID_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(MAX_BURST);

    arb_state_t      state_reg, state_next;
    logic [N_CH-1:0] grant_reg, grant_next;
    logic [ID_W-1:0] grant_idx_reg, grant_idx_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [ID_W-1:0] y_id_reg;
    logic            y_last_reg;

    logic [N_CH-1:0] pick_onehot;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;
    logic            accept;
    logic            last_beat;
    rgb888_t         ch_data [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_lane
            assign ch_data[gi] = bus.data[24*gi +: 24];
        end
    endgenerate

    rgb2grey_rr_pick #(.N_CH(N_CH), .ID_W(ID_W)) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign bus.ready = (state_reg == BURST) ? grant_reg : '0;
    assign accept    = (state_reg == BURST) && bus.valid[grant_idx_reg];
    // A burst closes on the requester's last or when the grant has used its beat budget.
    assign last_beat = bus.last[grant_idx_reg] || (beat_cnt_reg == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_idx_next = grant_idx_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_cnt_next  = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next     = BURST;
                    grant_next     = pick_onehot;
                    grant_idx_next = pick_idx;
                    rr_ptr_next    = (pick_idx == ID_W'(N_CH - 1)) ? '0 : pick_idx + ID_W'(1);
                    beat_cnt_next  = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    if (last_beat) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            rr_ptr_reg    <= '0;
            beat_cnt_reg  <= '0;
            y_id_reg      <= '0;
            y_last_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_idx_reg <= grant_idx_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            y_last_reg    <= accept && last_beat;
            if (accept) begin
                y_id_reg <= grant_idx_reg;
            end
        end
    end

    assign bus.grant  = grant_reg;
    assign bus.y_id   = y_id_reg;
    assign bus.y_last = y_last_reg;

    // Tag pipeline above is one stage deep to line up with the registered converter.
    rgb2grey #(.OUT_REG(1'b1)) u_conv (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (accept),
        .data_i  (ch_data[grant_idx_reg]),
        .done_o  (bus.y_valid),
        .data_o  (bus.y_data)
    );
endmodule
